// File: rtl/ps2_uart_tx_buffer.sv
// Byte FIFO feeding an 8N1 UART transmitter; sits after ps2_host_top on the PC-bound path.
// Back-pressure flags are derived from the registered occupancy count.
module ps2_uart_tx_buffer #(
  parameter int unsigned DEPTH        = 16,
  parameter int unsigned AF_LEVEL     = 15,
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     uart_wr_en,
  input  logic [7:0]               uart_wr_data,
  output logic                     uart_tx_full,
  output logic                     uart_tx_almost_full,
  output logic                     uart_txd,
  output logic                     tx_busy,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     overflow
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;
  localparam int unsigned BW = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BaudLast = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } tx_state_e;

  // FIFO state
  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_wptr;
  logic [AW-1:0] r_rptr;
  logic [CW-1:0] r_count;
  logic          r_overflow;

  // Transmitter state
  tx_state_e     r_state;
  tx_state_e     w_state_nxt;
  logic [BW-1:0] r_baud;
  logic [BW-1:0] w_baud_nxt;
  logic [2:0]    r_bit_idx;
  logic [2:0]    w_bit_idx_nxt;
  logic [7:0]    r_shift;
  logic [7:0]    w_shift_nxt;
  logic          r_txd;
  logic          w_txd_nxt;

  logic          w_full;
  logic          w_not_empty;
  logic          w_baud_end;
  logic          w_pop;
  logic          w_push;
  logic          w_drop;
  logic [7:0]    w_rd_data;
  logic [CW-1:0] w_count_nxt;

  assign w_full      = (r_count == CW'(DEPTH));
  assign w_not_empty = (r_count != '0);
  assign w_baud_end  = (r_baud == BaudLast);
  assign w_rd_data   = r_mem[r_rptr];

  // A pop in the same cycle frees a slot, so a write to a full FIFO is still accepted.
  assign w_push = uart_wr_en & (~w_full | w_pop);
  assign w_drop = uart_wr_en & w_full & ~w_pop;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + CW'(1);
    end else if (w_pop && !w_push) begin
      w_count_nxt = r_count - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wptr] <= uart_wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wptr     <= '0;
      r_rptr     <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) begin
        r_wptr <= r_wptr + AW'(1);
      end
      if (w_pop) begin
        r_rptr <= r_rptr + AW'(1);
      end
      r_count <= w_count_nxt;
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  // Next-state logic; txd is computed one cycle ahead so the line comes straight from a flop.
  always_comb begin
    w_state_nxt   = r_state;
    w_baud_nxt    = r_baud;
    w_bit_idx_nxt = r_bit_idx;
    w_shift_nxt   = r_shift;
    w_txd_nxt     = r_txd;
    w_pop         = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_txd_nxt = 1'b1;
        if (w_not_empty) begin
          w_pop       = 1'b1;
          w_shift_nxt = w_rd_data;
          w_baud_nxt  = '0;
          w_state_nxt = StStart;
          w_txd_nxt   = 1'b0;
        end
      end
      StStart: begin
        if (w_baud_end) begin
          w_baud_nxt    = '0;
          w_bit_idx_nxt = '0;
          w_state_nxt   = StData;
          w_txd_nxt     = r_shift[0];
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      StData: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = StStop;
            w_txd_nxt   = 1'b1;
          end else begin
            w_shift_nxt   = {1'b0, r_shift[7:1]};
            w_txd_nxt     = r_shift[1];
            w_bit_idx_nxt = r_bit_idx + 3'd1;
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
      StStop: begin
        if (w_baud_end) begin
          w_baud_nxt = '0;
          // Chain straight into the next start bit when more data is waiting.
          if (w_not_empty) begin
            w_pop       = 1'b1;
            w_shift_nxt = w_rd_data;
            w_state_nxt = StStart;
            w_txd_nxt   = 1'b0;
          end else begin
            w_state_nxt = StIdle;
            w_txd_nxt   = 1'b1;
          end
        end else begin
          w_baud_nxt = r_baud + BW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state   <= StIdle;
      r_baud    <= '0;
      r_bit_idx <= '0;
      r_shift   <= '0;
      r_txd     <= 1'b1;
    end else begin
      r_state   <= w_state_nxt;
      r_baud    <= w_baud_nxt;
      r_bit_idx <= w_bit_idx_nxt;
      r_shift   <= w_shift_nxt;
      r_txd     <= w_txd_nxt;
    end
  end

  assign uart_txd            = r_txd;
  assign tx_busy             = (r_state != StIdle);
  assign fifo_count          = r_count;
  assign uart_tx_full        = w_full;
  assign uart_tx_almost_full = (r_count >= CW'(AF_LEVEL));
  assign overflow            = r_overflow;

endmodule

// File: tb/tb_ps2_uart_tx_buffer.sv
// Bench for ps2_uart_tx_buffer: queued expected bytes are matched by a serial-line decoder,
// alongside directed timing, flag, overflow and reset checks.
module tb_ps2_uart_tx_buffer;

  localparam int unsigned Cpb     = 4;
  localparam int unsigned Depth   = 16;
  localparam int unsigned AfLevel = 15;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       wr_en = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       uart_tx_full;
  logic       uart_tx_almost_full;
  logic       uart_txd;
  logic       tx_busy;
  logic [4:0] fifo_count;
  logic       overflow;

  ps2_uart_tx_buffer #(
    .DEPTH       (Depth),
    .AF_LEVEL    (AfLevel),
    .CLKS_PER_BIT(Cpb)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .uart_wr_en         (wr_en),
    .uart_wr_data       (wr_data),
    .uart_tx_full       (uart_tx_full),
    .uart_tx_almost_full(uart_tx_almost_full),
    .uart_txd           (uart_txd),
    .tx_busy            (tx_busy),
    .fifo_count         (fifo_count),
    .overflow           (overflow)
  );

  always #5 clk = ~clk;

  int         n_checks = 0;
  int         n_errors = 0;
  logic [7:0] exp_q[$];
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Serial decoder: mid-bit sampling of an 8N1 frame, compared against the expected queue.
  initial begin
    bit         mon_in;
    int         mon_pos;
    logic [7:0] mon_byte;
    logic [7:0] exp_b;
    mon_in   = 1'b0;
    mon_pos  = 0;
    mon_byte = 8'h00;
    forever begin
      @(negedge clk);
      if (!rst || !mon_en) begin
        mon_in = 1'b0;
      end else if (!mon_in) begin
        if (uart_txd == 1'b0) begin
          mon_in  = 1'b1;
          mon_pos = 0;
        end
      end else begin
        mon_pos++;
        if (mon_pos == Cpb / 2) begin
          check("start_bit", uart_txd, 0);
        end else if (mon_pos >= 6 && mon_pos <= 34 && ((mon_pos - 2) % 4) == 0) begin
          mon_byte[(mon_pos - 6) / 4] = uart_txd;
        end else if (mon_pos == 38) begin
          check("stop_bit", uart_txd, 1);
          if (exp_q.size() == 0) begin
            n_checks++;
            n_errors++;
            $display("FAIL unexpected_frame: got 0x%0h, expected no frame", mon_byte);
          end else begin
            exp_b = exp_q.pop_front();
            check("serial_byte", mon_byte, exp_b);
          end
          mon_in = 1'b0;
        end
      end
    end
  end

  initial begin
    #900000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  task automatic drive_write(input logic [7:0] b, input bit accept);
    wr_en   = 1'b1;
    wr_data = b;
    if (accept) exp_q.push_back(b);
  endtask

  task automatic do_reset();
    mon_en = 1'b0;
    wr_en  = 1'b0;
    rst    = 1'b0;
    exp_q.delete();
    repeat (3) @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;
  endtask

  task automatic drain(input int limit);
    int i;
    i = 0;
    while ((exp_q.size() != 0 || tx_busy) && i < limit) begin
      @(negedge clk);
      i++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_idle", tx_busy, 0);
  endtask

  initial begin
    logic [7:0] b;
    logic       exp_bit;
    int         run;
    int         lows;
    int         sent;
    int         cyc;
    int         cnt;

    // Reset values while rst is held low
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_txd", uart_txd, 1);
    check("rst_busy", tx_busy, 0);
    check("rst_full", uart_tx_full, 0);
    check("rst_afull", uart_tx_almost_full, 0);
    check("rst_count", fifo_count, 0);
    check("rst_overflow", overflow, 0);
    rst    = 1'b1;
    mon_en = 1'b1;
    repeat (2) @(negedge clk);

    // Single byte 0x41: exact waveform
    b = 8'h41;
    @(negedge clk);
    drive_write(b, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    check("t1_count_after_write", fifo_count, 1);
    check("t1_txd_before_load", uart_txd, 1);
    check("t1_busy_before_load", tx_busy, 0);
    for (int t = 0; t < 10 * Cpb; t++) begin
      @(negedge clk);
      if (t < Cpb) exp_bit = 1'b0;
      else if (t < 9 * Cpb) exp_bit = b[(t - Cpb) / Cpb];
      else exp_bit = 1'b1;
      check("t1_txd_wave", uart_txd, exp_bit);
      check("t1_busy_wave", tx_busy, 1);
      if (t == 0) check("t1_count_after_load", fifo_count, 0);
    end
    @(negedge clk);
    check("t1_busy_end", tx_busy, 0);
    check("t1_txd_end", uart_txd, 1);
    drain(100);

    // Two back-to-back bytes: busy continuous for two frames
    @(negedge clk);
    drive_write(8'h0A, 1'b1);
    @(negedge clk);
    drive_write(8'h55, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    run = 0;
    for (int i = 0; i < 200; i++) begin
      if (tx_busy) run++;
      else if (run > 0) break;
      @(negedge clk);
    end
    check("t2_busy_run", run, 20 * Cpb);
    drain(200);

    // Fill to full, then one dropped write
    for (int i = 0; i <= 16; i++) begin
      @(negedge clk);
      drive_write(8'h80 + 8'(i), 1'b1);
      @(posedge clk);
      #1;
      cnt = (i == 0) ? 1 : i;
      check("t3_count", fifo_count, cnt);
      check("t3_afull", uart_tx_almost_full, (cnt >= int'(AfLevel)) ? 1 : 0);
      check("t3_full", uart_tx_full, (cnt == int'(Depth)) ? 1 : 0);
      check("t3_overflow_clear", overflow, 0);
    end
    @(negedge clk);
    drive_write(8'hEE, 1'b0);
    @(posedge clk);
    #1;
    check("t3_overflow_set", overflow, 1);
    check("t3_count_after_drop", fifo_count, 16);
    @(negedge clk);
    wr_en = 1'b0;
    drain(17 * 10 * Cpb + 100);
    check("t3_overflow_sticky", overflow, 1);

    // Write on the exact pop cycle while full
    do_reset();
    check("t4_overflow_reset", overflow, 0);
    for (int k = 0; k <= 41; k++) begin
      @(negedge clk);
      if (k <= 16) begin
        drive_write(8'h20 + 8'(k), 1'b1);
      end else if (k == 41) begin
        check("t4_full_before_pop", uart_tx_full, 1);
        drive_write(8'hC3, 1'b1);
      end else begin
        wr_en = 1'b0;
      end
    end
    @(posedge clk);
    #1;
    check("t4_count_kept", fifo_count, 16);
    check("t4_full_kept", uart_tx_full, 1);
    check("t4_no_overflow", overflow, 0);
    @(negedge clk);
    wr_en = 1'b0;
    drain(18 * 10 * Cpb + 100);
    check("t4_no_overflow_end", overflow, 0);

    // Reset during data bit 3 with 5 bytes queued
    do_reset();
    for (int k = 0; k <= 18; k++) begin
      @(negedge clk);
      if (k <= 5) drive_write(8'h60 + 8'(k), 1'b1);
      else wr_en = 1'b0;
    end
    @(negedge clk);
    check("t5_queued", fifo_count, 5);
    mon_en = 1'b0;
    rst    = 1'b0;
    #1;
    check("t5_rst_txd", uart_txd, 1);
    check("t5_rst_count", fifo_count, 0);
    check("t5_rst_full", uart_tx_full, 0);
    check("t5_rst_afull", uart_tx_almost_full, 0);
    check("t5_rst_busy", tx_busy, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    rst    = 1'b1;
    mon_en = 1'b1;
    lows = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (uart_txd !== 1'b1 || tx_busy !== 1'b0) lows++;
    end
    check("t5_quiet_after_reset", lows, 0);
    @(negedge clk);
    drive_write(8'h3C, 1'b1);
    @(negedge clk);
    wr_en = 1'b0;
    drain(100);

    // Random stream honouring back-pressure
    sent = 0;
    cyc  = 0;
    while (sent < 500 && cyc < 40000) begin
      @(negedge clk);
      cyc++;
      if (!uart_tx_full && $urandom_range(0, 3) != 0) begin
        drive_write(8'($urandom), 1'b1);
        sent++;
      end else begin
        wr_en = 1'b0;
      end
    end
    @(negedge clk);
    wr_en = 1'b0;
    check("t6_all_sent", sent, 500);
    drain(20 * 10 * Cpb + 200);
    check("t6_no_overflow", overflow, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
